// File: rtl/arqui_param_pkg.sv
// ---------------------------------------------------------------------------
// arqui_param_pkg
// Shared types and helpers for the arqui_param packet switch fabric.
//   state_t       : control FSM encoding (INIT=0, IDLE=1, ACTIVE=2, ERROR=3)
//   clog2_min1    : index width that never collapses to zero bits
//   err_*_bit     : bit positions inside error_out
//   def_af/def_ae : threshold values loaded at reset
// ---------------------------------------------------------------------------
package arqui_param_pkg;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_ERROR  = 2'd3
    } state_t;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int err_main_bit();
        return 0;
    endfunction

    function automatic int err_vc_bit(input int vc);
        return 1 + vc;
    endfunction

    function automatic int err_dest_bit(input int num_vc, input int dest);
        return 1 + num_vc + dest;
    endfunction

    function automatic int def_af(input int depth);
        return depth - 1;
    endfunction

    function automatic int def_ae();
        return 1;
    endfunction

endpackage

// File: rtl/arqui_param_fifo_th.sv
// ---------------------------------------------------------------------------
// fifo_th
// Synchronous FIFO with programmable almost-full / almost-empty thresholds.
// Ports:
//   clk, reset        : clock, synchronous active-high reset (empties FIFO)
//   i_push / i_din    : write request and data
//   i_pop             : read request (head advances)
//   i_af_th / i_ae_th : almost-full (count >= af) / almost-empty (count <= ae)
//   o_head            : current head word (valid when not empty)
//   o_count           : occupancy, $clog2(DEPTH)+1 bits
//   o_full, o_empty, o_afull, o_aempty : status from the registered count
//   o_ovf, o_udf      : single-cycle pulses for a dropped push / rejected pop
// A pop frees a slot in the same edge, so a full FIFO still accepts a push
// accompanied by a pop; an empty FIFO never serves a pop, even with a push.
// ---------------------------------------------------------------------------
module fifo_th #(
    parameter int DEPTH = 4,
    parameter int DW    = 6,
    parameter int THW   = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           i_push,
    input  logic           i_pop,
    input  logic [DW-1:0]  i_din,
    input  logic [THW-1:0] i_af_th,
    input  logic [THW-1:0] i_ae_th,
    output logic [DW-1:0]  o_head,
    output logic [$clog2(DEPTH):0] o_count,
    output logic           o_full,
    output logic           o_empty,
    output logic           o_afull,
    output logic           o_aempty,
    output logic           o_ovf,
    output logic           o_udf
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_full;
    logic          w_empty;
    logic          w_do_push;
    logic          w_do_pop;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
            else if (w_do_pop && !w_do_push) r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_din;
    end

    assign o_head   = r_mem[r_rd_ptr];
    assign o_count  = r_count;
    assign o_full   = w_full;
    assign o_empty  = w_empty;
    assign o_afull  = (r_count >= CW'(i_af_th));
    assign o_aempty = (r_count <= CW'(i_ae_th));
    assign o_ovf    = i_push && w_full && !w_do_pop;
    assign o_udf    = i_pop && w_empty;

endmodule

// File: rtl/arqui_param.sv
// ---------------------------------------------------------------------------
// arqui_param
// Packet switch fabric: main FIFO -> NUM_VC virtual-channel FIFOs (by class
// bits) -> NUM_DEST destination FIFOs (by destination bits).
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   init                  : hold INIT and latch the six thresholds
//   data_in / push_main   : input word and its write strobe
//   pop_d                 : per-destination pop
//   afMF_i..aeDF_i        : almost-full / almost-empty thresholds
//   data_out              : registered pop data, slice k = [k*DW +: DW]
//   fifo_pause_main       : main FIFO almost full
//   fifo_empty_d          : per-destination empty
//   error_out             : sticky {dest underflow, VC overflow, main overflow}
//   active_out / idle_out : FSM in ACTIVE / IDLE
// Build option: define VC_RR_ARB_EN for a round-robin VC->dest arbiter;
// otherwise the lowest eligible VC index wins.
// ---------------------------------------------------------------------------
module arqui_param
    import arqui_param_pkg::*;
#(
    parameter int DW       = 6,
    parameter int NUM_VC   = 2,
    parameter int NUM_DEST = 2,
    parameter int MF_DEPTH = 4,
    parameter int VC_DEPTH = 16,
    parameter int DF_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        init,
    input  logic [DW-1:0]               data_in,
    input  logic                        push_main,
    input  logic [NUM_DEST-1:0]         pop_d,
    input  logic [$clog2(MF_DEPTH)-1:0] afMF_i,
    input  logic [$clog2(MF_DEPTH)-1:0] aeMF_i,
    input  logic [$clog2(VC_DEPTH)-1:0] afVC_i,
    input  logic [$clog2(VC_DEPTH)-1:0] aeVC_i,
    input  logic [$clog2(DF_DEPTH)-1:0] afDF_i,
    input  logic [$clog2(DF_DEPTH)-1:0] aeDF_i,
    output logic [NUM_DEST*DW-1:0]      data_out,
    output logic                        fifo_pause_main,
    output logic [NUM_DEST-1:0]         fifo_empty_d,
    output logic [NUM_VC+NUM_DEST:0]    error_out,
    output logic                        active_out,
    output logic                        idle_out
);
    localparam int VCW  = clog2_min1(NUM_VC);
    localparam int DSW  = clog2_min1(NUM_DEST);
    localparam int MTW  = $clog2(MF_DEPTH);
    localparam int VTW  = $clog2(VC_DEPTH);
    localparam int DTW  = $clog2(DF_DEPTH);
    localparam int MCW  = MTW + 1;
    localparam int VCCW = VTW + 1;
    localparam int DCW  = DTW + 1;
    localparam int EW   = 1 + NUM_VC + NUM_DEST;

    state_t                  r_state;
    logic                    r_active;
    logic                    r_idle;
    logic [EW-1:0]           r_err;
    logic [NUM_DEST*DW-1:0]  r_data_out;
    logic [MTW-1:0]          r_af_mf, r_ae_mf;
    logic [VTW-1:0]          r_af_vc, r_ae_vc;
    logic [DTW-1:0]          r_af_df, r_ae_df;

    logic [DW-1:0]  w_mf_head;
    logic [MCW-1:0] w_mf_cnt;
    logic           w_mf_full, w_mf_empty, w_mf_afull, w_mf_aempty, w_mf_ovf, w_mf_udf;

    logic [DW-1:0]   w_vc_head [NUM_VC];
    logic [DSW-1:0]  w_vc_dest [NUM_VC];
    logic [VCCW-1:0] w_vc_cnt  [NUM_VC];
    logic [NUM_VC-1:0] w_vc_push, w_vc_pop, w_vc_full, w_vc_empty;
    logic [NUM_VC-1:0] w_vc_afull, w_vc_aempty, w_vc_ovf, w_vc_udf;

    logic [DW-1:0]   w_df_head [NUM_DEST];
    logic [DCW-1:0]  w_df_cnt  [NUM_DEST];
    logic [NUM_DEST-1:0] w_df_push, w_df_full, w_df_empty;
    logic [NUM_DEST-1:0] w_df_afull, w_df_aempty, w_df_ovf, w_df_udf;

    logic           w_fwd_en;
    logic [VCW-1:0] w_mf_vc;
    logic           w_s1_go;
    logic [NUM_VC-1:0] w_elig;
    logic           w_gnt_vld;
    logic [VCW-1:0] w_gnt_idx;
    logic [DW-1:0]  w_gnt_head;
    logic [DSW-1:0] w_gnt_dest;
    logic [EW-1:0]  w_err_new;
    logic           w_any_data;

    assign w_fwd_en   = (r_state == ST_IDLE) || (r_state == ST_ACTIVE);
    assign w_any_data = !(w_mf_empty && (&w_vc_empty) && (&w_df_empty));

    // ---- main FIFO ----
    fifo_th #(.DEPTH(MF_DEPTH), .DW(DW), .THW(MTW)) u_main (
        .clk(clk), .reset(reset), .i_push(push_main), .i_pop(w_s1_go), .i_din(data_in),
        .i_af_th(r_af_mf), .i_ae_th(r_ae_mf), .o_head(w_mf_head), .o_count(w_mf_cnt),
        .o_full(w_mf_full), .o_empty(w_mf_empty), .o_afull(w_mf_afull),
        .o_aempty(w_mf_aempty), .o_ovf(w_mf_ovf), .o_udf(w_mf_udf)
    );

    a_mf_ok: assert property (@(posedge clk) disable iff (reset)
        !w_mf_udf && (w_mf_full == (w_mf_cnt == MCW'(MF_DEPTH)))
        && (w_mf_aempty == (w_mf_cnt <= MCW'(r_ae_mf))));

    // ---- stage 1: main -> VC (pop and push in the same edge) ----
    assign w_mf_vc = w_mf_head[DW-1 -: VCW];
    assign w_s1_go = w_fwd_en && !w_mf_empty && !w_vc_afull[w_mf_vc];

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        assign w_vc_push[v] = w_s1_go && (w_mf_vc == VCW'(v));
        assign w_vc_pop[v]  = w_gnt_vld && (w_gnt_idx == VCW'(v));
        assign w_vc_dest[v] = w_vc_head[v][DW-1-VCW -: DSW];

        fifo_th #(.DEPTH(VC_DEPTH), .DW(DW), .THW(VTW)) u_vc (
            .clk(clk), .reset(reset), .i_push(w_vc_push[v]), .i_pop(w_vc_pop[v]),
            .i_din(w_mf_head), .i_af_th(r_af_vc), .i_ae_th(r_ae_vc),
            .o_head(w_vc_head[v]), .o_count(w_vc_cnt[v]), .o_full(w_vc_full[v]),
            .o_empty(w_vc_empty[v]), .o_afull(w_vc_afull[v]), .o_aempty(w_vc_aempty[v]),
            .o_ovf(w_vc_ovf[v]), .o_udf(w_vc_udf[v])
        );

        // Stage 1 only pushes below almost-full, so a VC can never overflow.
        a_vc_ok: assert property (@(posedge clk) disable iff (reset)
            !w_vc_ovf[v] && !w_vc_udf[v]
            && (w_vc_full[v] == (w_vc_cnt[v] == VCCW'(VC_DEPTH)))
            && (w_vc_aempty[v] == (w_vc_cnt[v] <= VCCW'(r_ae_vc))));
    end

    // ---- stage 2: VC -> destination arbitration ----
    always_comb begin
        w_elig = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            w_elig[v] = w_fwd_en && !w_vc_empty[v] && !w_df_afull[w_vc_dest[v]];
        end
    end

`ifdef VC_RR_ARB_EN
    logic [VCW-1:0] r_rr_ptr;
    logic [VCW-1:0] w_cand;

    // Search starts at the pointer; the first eligible VC wins.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_cand    = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            w_cand = r_rr_ptr + VCW'(i);
            if (!w_gnt_vld && (int'(w_cand) < NUM_VC) && w_elig[w_cand]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)          r_rr_ptr <= '0;
        else if (w_gnt_vld) r_rr_ptr <= w_gnt_idx + VCW'(1);
    end
`else
    // Scan downwards so the lowest eligible index is the last assignment.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        for (int i = NUM_VC - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = VCW'(i);
            end
        end
    end
`endif

    assign w_gnt_head = w_vc_head[w_gnt_idx];
    assign w_gnt_dest = w_vc_dest[w_gnt_idx];

    // ---- destination FIFOs ----
    for (genvar k = 0; k < NUM_DEST; k++) begin : g_df
        assign w_df_push[k] = w_gnt_vld && (w_gnt_dest == DSW'(k));

        fifo_th #(.DEPTH(DF_DEPTH), .DW(DW), .THW(DTW)) u_df (
            .clk(clk), .reset(reset), .i_push(w_df_push[k]), .i_pop(pop_d[k]),
            .i_din(w_gnt_head), .i_af_th(r_af_df), .i_ae_th(r_ae_df),
            .o_head(w_df_head[k]), .o_count(w_df_cnt[k]), .o_full(w_df_full[k]),
            .o_empty(w_df_empty[k]), .o_afull(w_df_afull[k]), .o_aempty(w_df_aempty[k]),
            .o_ovf(w_df_ovf[k]), .o_udf(w_df_udf[k])
        );

        a_df_ok: assert property (@(posedge clk) disable iff (reset)
            !w_df_ovf[k]
            && (w_df_full[k] == (w_df_cnt[k] == DCW'(DF_DEPTH)))
            && (w_df_aempty[k] == (w_df_cnt[k] <= DCW'(r_ae_df))));
    end

    // ---- pop data register: an underflowing pop leaves its slice unchanged ----
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_out <= '0;
        end else begin
            for (int k = 0; k < NUM_DEST; k++) begin
                if (pop_d[k] && !w_df_empty[k]) r_data_out[k*DW +: DW] <= w_df_head[k];
            end
        end
    end

    // ---- error collection ----
    always_comb begin
        w_err_new = '0;
        w_err_new[err_main_bit()] = w_mf_ovf;
        for (int v = 0; v < NUM_VC; v++)   w_err_new[err_vc_bit(v)] = w_vc_ovf[v];
        for (int k = 0; k < NUM_DEST; k++) w_err_new[err_dest_bit(NUM_VC, k)] = w_df_udf[k];
    end

    // ---- control FSM with registered status outputs ----
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_INIT;
            r_active <= 1'b0;
            r_idle   <= 1'b0;
            r_err    <= '0;
            r_af_mf  <= MTW'(def_af(MF_DEPTH));
            r_ae_mf  <= MTW'(def_ae());
            r_af_vc  <= VTW'(def_af(VC_DEPTH));
            r_ae_vc  <= VTW'(def_ae());
            r_af_df  <= DTW'(def_af(DF_DEPTH));
            r_ae_df  <= DTW'(def_ae());
        end else begin
            r_err <= r_err | w_err_new;
            if ((r_state == ST_INIT) && init) begin
                r_af_mf <= afMF_i;
                r_ae_mf <= aeMF_i;
                r_af_vc <= afVC_i;
                r_ae_vc <= aeVC_i;
                r_af_df <= afDF_i;
                r_ae_df <= aeDF_i;
            end
            if (|w_err_new) begin
                r_state  <= ST_ERROR;
                r_active <= 1'b0;
                r_idle   <= 1'b0;
            end else begin
                case (r_state)
                    ST_INIT: begin
                        if (!init) begin
                            r_state <= ST_IDLE;
                            r_idle  <= 1'b1;
                        end
                    end
                    ST_IDLE: begin
                        if (init) begin
                            r_state <= ST_INIT;
                            r_idle  <= 1'b0;
                        end else if (w_any_data) begin
                            r_state  <= ST_ACTIVE;
                            r_active <= 1'b1;
                            r_idle   <= 1'b0;
                        end
                    end
                    ST_ACTIVE: begin
                        if (init) begin
                            r_state  <= ST_INIT;
                            r_active <= 1'b0;
                        end else if (!w_any_data) begin
                            r_state  <= ST_IDLE;
                            r_active <= 1'b0;
                            r_idle   <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign data_out        = r_data_out;
    assign fifo_pause_main = w_mf_afull;
    assign fifo_empty_d    = w_df_empty;
    assign error_out       = r_err;
    assign active_out      = r_active;
    assign idle_out        = r_idle;

endmodule
